dmem_controller: RTL and testbench
==================================

Name: dmem_controller

Overview:
- Data-memory controller sitting directly downstream of the rv32i_cpu data port; services one load or store at a time.
- Converts the CPU's byte address, size and lane-0 store data/mask into a word-wide synchronous SRAM access.
- Returns loads right-aligned to lane 0 so the CPU's sign extension on data_read[7]/[15] is correct.
- Pulses cpu_valid on completion and flags misaligned accesses without touching SRAM.

Parameters:
- DMEM_WIDTH, 16, byte-address width of the CPU data port.
- WAIT_STATES, 0, extra SRAM read-latency cycles beyond 1 (0..15).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_addr  in  DMEM_WIDTH  byte address.
- cpu_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- cpu_we  in  4  lane-0-relative write mask; 0 means load.
- cpu_wdata  in  32  lane-0-relative store data.
- cpu_rdata  out  32  load data, right-aligned, zero-filled above size.
- cpu_valid  out  1  one-cycle completion pulse.
- cpu_err  out  1  misalignment flag; valid with cpu_valid.
- cpu_busy  out  1  high whenever state != IDLE.
- sram_en  out  1  SRAM enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  DMEM_WIDTH-2  word address, cpu_addr[DMEM_WIDTH-1:2].
- sram_wdata  out  32  lane-shifted store data.
- sram_rdata  in  32  SRAM read data; valid 1+WAIT_STATES cycles after the sram_en cycle.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0; request latches and wait counter 0. Reset mid-access aborts immediately: sram_en and sram_we drop combinationally with reset, and no cpu_valid is issued. A store aborted this way may or may not have been written.
- All outputs are registered.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - cpu_req=1 at edge T latches addr, size, we and wdata.
  - Misaligned request (half with addr[0]=1; word with addr[1:0]!=0): go to DONE with cpu_err=1, cpu_rdata=0, no SRAM cycle.
  - Otherwise go to ACCESS.
- ACCESS (cycle T+1):
  - sram_en=1 for exactly this cycle.
  - sram_we = (cpu_we & size mask) << addr[1:0]. Size mask: byte 0001, half 0011, word 1111.
  - sram_wdata = cpu_wdata << 8*addr[1:0].
  - Store goes to DONE; load goes to WAIT, counter cleared.
- WAIT:
  - Stays WAIT_STATES+1 cycles.
  - On the last cycle, captures cpu_rdata = (sram_rdata >> 8*addr[1:0]) masked to size, then goes to DONE.
- DONE: cpu_valid=1 (and cpu_err if flagged) for one cycle, then IDLE. cpu_req during DONE is ignored.
- cpu_rdata holds its value until the next load capture; stores do not change it.
- Latency from the req edge T:
  - Store: cpu_valid in cycle T+2.
  - Load: cpu_valid in cycle T+3+WAIT_STATES.
  - Misaligned: cpu_valid in cycle T+1.
- Back-to-back requests: a request can be accepted at the earliest in the cycle after cpu_valid.
- sram_en is never asserted outside ACCESS; sram_we is 0 outside ACCESS.
- Width rules: shifts use addr[1:0] only. Upper address bits pass through unchanged, so no wrap handling is needed.

Test Plan:
- Reset: hold reset=0, then release → all outputs 0, cpu_busy=0. Assert reset=0 in the middle of a load in WAIT → sram_en=0 and state IDLE immediately, no cpu_valid.
- Word store then load, WAIT_STATES=0:
  - Store addr=0x0010, size=10, we=1111, wdata=0xDEADBEEF → sram_en/we=1111 at T+1, sram_addr=0x004, cpu_valid at T+2.
  - Load same address → cpu_rdata=0xDEADBEEF, cpu_valid at T+3.
- Byte store: addr=0x0013, size=00, we=0001, wdata=0x000000AB → sram_we=1000, sram_wdata=0xAB000000. Subsequent byte load from 0x0013 → cpu_rdata=0x000000AB.
- Half load: addr=0x0012 with sram word 0x8001_7FFF → cpu_rdata=0x00008001. With WAIT_STATES=3, cpu_valid arrives at T+6.
- Misaligned: word at 0x0011 and half at 0x0015 → cpu_valid and cpu_err at T+1, cpu_rdata=0, sram_en never asserted.
- Back-to-back: cpu_req held high continuously → accesses are accepted only in IDLE; exactly one sram_en per cpu_valid, and requests during DONE are ignored.

Source files
------------

// File: rtl/dmem_controller_if.sv
// -----------------------------------------------------------------------------
// dmem_controller_if
//   Bundles the CPU data-port handshake and the synchronous SRAM port of the
//   data-memory controller.
//   - slave  : view of the controller (CPU request and SRAM read data in,
//              CPU response and SRAM command out).
//   - master : view of the environment (CPU plus SRAM) that drives the
//              controller's inputs and observes its outputs.
//   Signals:
//     cpu_req/cpu_addr/cpu_size/cpu_we/cpu_wdata  CPU request, lane-0 relative
//     cpu_rdata/cpu_valid/cpu_err/cpu_busy        CPU response and status
//     sram_en/sram_we/sram_addr/sram_wdata        SRAM command (word wide)
//     sram_rdata                                  SRAM read data
// -----------------------------------------------------------------------------
interface dmem_controller_if #(
  parameter int DMEM_WIDTH = 16
);
  logic                  cpu_req;
  logic [DMEM_WIDTH-1:0] cpu_addr;
  logic [1:0]            cpu_size;
  logic [3:0]            cpu_we;
  logic [31:0]           cpu_wdata;
  logic [31:0]           cpu_rdata;
  logic                  cpu_valid;
  logic                  cpu_err;
  logic                  cpu_busy;
  logic                  sram_en;
  logic [3:0]            sram_we;
  logic [DMEM_WIDTH-3:0] sram_addr;
  logic [31:0]           sram_wdata;
  logic [31:0]           sram_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_size, cpu_we, cpu_wdata, sram_rdata,
    output cpu_rdata, cpu_valid, cpu_err, cpu_busy,
           sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output cpu_req, cpu_addr, cpu_size, cpu_we, cpu_wdata, sram_rdata,
    input  cpu_rdata, cpu_valid, cpu_err, cpu_busy,
           sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/dmem_controller.sv
// -----------------------------------------------------------------------------
// dmem_controller
//   Data-memory controller between the rv32i_cpu data port and a word-wide
//   synchronous SRAM. Handles one load or store at a time: lane-shifts store
//   data and byte enables, right-aligns and zero-fills load data, and reports
//   misaligned half/word accesses without issuing an SRAM cycle.
//   Ports:
//     clk    clock
//     reset  asynchronous, active-low reset
//     bus    dmem_controller_if.slave (CPU request/response, SRAM command/data)
//   Parameters:
//     DMEM_WIDTH   byte-address width of the CPU data port
//     WAIT_STATES  extra SRAM read-latency cycles beyond 1 (0..15)
//   Latency from the accepting edge T: store valid in T+2, load valid in
//   T+3+WAIT_STATES, misaligned valid in T+1. All outputs are registers, so an
//   asserted reset clears sram_en/sram_we immediately.
// -----------------------------------------------------------------------------
module dmem_controller #(
  parameter int DMEM_WIDTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               reset,
  dmem_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  state_t      state_r;
  logic [1:0]  off_r;       // byte offset of the accepted request
  logic [1:0]  size_r;      // size of the accepted request
  logic        store_r;     // accepted request is a store
  logic [3:0]  wait_cnt_r;  // cycles already spent in WAIT

  logic [1:0]  off_s;
  logic [3:0]  we_lane_s;
  logic [31:0] wdata_lane_s;
  logic [31:0] rdata_lane_s;

  // Byte-enable mask for an access size; size 11 behaves as a word.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Bit mask that zero-fills load data above the access size.
  function automatic logic [31:0] data_mask(input logic [1:0] size);
    case (size)
      2'b00:   data_mask = 32'h0000_00FF;
      2'b01:   data_mask = 32'h0000_FFFF;
      default: data_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  // Lane steering: stores are computed from the live request because the SRAM
  // command register is loaded on the accepting edge; loads use the latched
  // offset/size because the data arrives several cycles later.
  assign off_s        = bus.cpu_addr[1:0];
  assign we_lane_s    = (bus.cpu_we & size_mask(bus.cpu_size)) << off_s;
  assign wdata_lane_s = bus.cpu_wdata << {off_s, 3'b000};
  assign rdata_lane_s = (bus.sram_rdata >> {off_r, 3'b000}) & data_mask(size_r);

  // Access FSM with all CPU and SRAM outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      off_r          <= 2'b00;
      size_r         <= 2'b00;
      store_r        <= 1'b0;
      wait_cnt_r     <= 4'd0;
      bus.cpu_rdata  <= 32'h0000_0000;
      bus.cpu_valid  <= 1'b0;
      bus.cpu_err    <= 1'b0;
      bus.cpu_busy   <= 1'b0;
      bus.sram_en    <= 1'b0;
      bus.sram_we    <= 4'b0000;
      bus.sram_addr  <= '0;
      bus.sram_wdata <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cpu_req) begin
            off_r         <= off_s;
            size_r        <= bus.cpu_size;
            store_r       <= (bus.cpu_we != 4'b0000);
            bus.sram_addr <= bus.cpu_addr[DMEM_WIDTH-1:2];
            bus.cpu_busy  <= 1'b1;
            if (is_misaligned(bus.cpu_size, off_s)) begin
              // No SRAM cycle: report the error straight away.
              state_r       <= ST_DONE;
              bus.cpu_valid <= 1'b1;
              bus.cpu_err   <= 1'b1;
              bus.cpu_rdata <= 32'h0000_0000;
            end else begin
              state_r        <= ST_ACCESS;
              bus.sram_en    <= 1'b1;
              bus.sram_we    <= we_lane_s;
              bus.sram_wdata <= wdata_lane_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ACCESS: begin
          bus.sram_en <= 1'b0;
          bus.sram_we <= 4'b0000;
          wait_cnt_r  <= 4'd0;
          if (store_r) begin
            state_r       <= ST_DONE;
            bus.cpu_valid <= 1'b1;
          end else begin
            state_r <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (wait_cnt_r == WAIT_LAST) begin
            state_r       <= ST_DONE;
            bus.cpu_rdata <= rdata_lane_s;
            bus.cpu_valid <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end

        ST_DONE: begin
          // Requests seen here are dropped; the next one is taken in IDLE.
          state_r       <= ST_IDLE;
          bus.cpu_valid <= 1'b0;
          bus.cpu_err   <= 1'b0;
          bus.cpu_busy  <= 1'b0;
        end

        default: begin
          state_r       <= ST_IDLE;
          bus.cpu_valid <= 1'b0;
          bus.cpu_err   <= 1'b0;
          bus.cpu_busy  <= 1'b0;
          bus.sram_en   <= 1'b0;
          bus.sram_we   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_controller.sv
// -----------------------------------------------------------------------------
// tb_dmem_controller
//   Directed bench for dmem_controller. Two instances (WAIT_STATES 0 and 3)
//   share the same CPU stimulus, each with its own behavioural SRAM whose read
//   data is valid for exactly one cycle, 1+WAIT_STATES cycles after sram_en.
//   Cycle numbers below count from the accepting edge T: cycle k is sampled on
//   the k-th falling edge after T. Index 0 = WAIT_STATES 0, index 1 = 3.
// -----------------------------------------------------------------------------
module tb_dmem_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        req_s;
  logic [15:0] addr_s;
  logic [1:0]  size_s;
  logic [3:0]  we_s;
  logic [31:0] wdata_s;

  dmem_controller_if #(.DMEM_WIDTH(16)) bus0 ();
  dmem_controller_if #(.DMEM_WIDTH(16)) bus3 ();

  dmem_controller #(.DMEM_WIDTH(16), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  dmem_controller #(.DMEM_WIDTH(16), .WAIT_STATES(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  // Clock generation.
  always #5 clk = ~clk;

  assign bus0.cpu_req = req_s;   assign bus3.cpu_req = req_s;
  assign bus0.cpu_addr = addr_s; assign bus3.cpu_addr = addr_s;
  assign bus0.cpu_size = size_s; assign bus3.cpu_size = size_s;
  assign bus0.cpu_we = we_s;     assign bus3.cpu_we = we_s;
  assign bus0.cpu_wdata = wdata_s; assign bus3.cpu_wdata = wdata_s;

  // SRAM models.
  logic [31:0] mem0 [0:16383];
  logic [31:0] mem3 [0:16383];
  logic [31:0] rd0_r;
  logic [31:0] pipe3_r [4];

  // SRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus0.sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus0.sram_we[b]) mem0[bus0.sram_addr][8*b +: 8] <= bus0.sram_wdata[8*b +: 8];
    end
    rd0_r <= (bus0.sram_en && bus0.sram_we == 4'b0000) ? mem0[bus0.sram_addr] : 32'h0BAD_0BAD;
  end
  assign bus0.sram_rdata = rd0_r;

  // SRAM with four cycles of read latency.
  always @(posedge clk) begin
    if (bus3.sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus3.sram_we[b]) mem3[bus3.sram_addr][8*b +: 8] <= bus3.sram_wdata[8*b +: 8];
    end
    pipe3_r[0] <= (bus3.sram_en && bus3.sram_we == 4'b0000) ? mem3[bus3.sram_addr] : 32'h0BAD_0BAD;
    pipe3_r[1] <= pipe3_r[0];
    pipe3_r[2] <= pipe3_r[1];
    pipe3_r[3] <= pipe3_r[2];
  end
  assign bus3.sram_rdata = pipe3_r[3];

  // Monitor views of both instances.
  logic [1:0]  m_en, m_valid, m_err, m_busy;
  logic [3:0]  m_we [2];
  logic [31:0] m_wdata [2];
  logic [13:0] m_addr [2];
  logic [31:0] m_rdata [2];
  assign m_en    = {bus3.sram_en, bus0.sram_en};
  assign m_valid = {bus3.cpu_valid, bus0.cpu_valid};
  assign m_err   = {bus3.cpu_err, bus0.cpu_err};
  assign m_busy  = {bus3.cpu_busy, bus0.cpu_busy};
  assign m_we[0] = bus0.sram_we;       assign m_we[1] = bus3.sram_we;
  assign m_wdata[0] = bus0.sram_wdata; assign m_wdata[1] = bus3.sram_wdata;
  assign m_addr[0] = bus0.sram_addr;   assign m_addr[1] = bus3.sram_addr;
  assign m_rdata[0] = bus0.cpu_rdata;  assign m_rdata[1] = bus3.cpu_rdata;

  // Per-access observations.
  int          r_en_cyc [2], r_en_cnt [2], r_val_cyc [2], r_val_cnt [2];
  logic [3:0]  r_we [2];
  logic [31:0] r_wdata [2];
  logic [13:0] r_addr [2];
  logic [31:0] r_rdata [2];
  logic        r_err [2];

  task automatic wait_idle();
    int n = 0;
    while (m_busy != 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (m_busy !== 2'b00) begin n_fail++; $display("FAIL idle_wait: busy=%b expected 00", m_busy); end
  endtask

  // Issues one request to both instances and records what happens over 30 cycles.
  task automatic run_access(input logic [15:0] a, input logic [1:0] sz, input logic [3:0] w, input logic [31:0] d);
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      r_en_cyc[i] = -1; r_en_cnt[i] = 0; r_val_cyc[i] = -1; r_val_cnt[i] = 0;
      r_we[i] = 4'h0; r_wdata[i] = 32'h0; r_addr[i] = 14'h0; r_rdata[i] = 32'h0; r_err[i] = 1'b0;
    end
    addr_s = a; size_s = sz; we_s = w; wdata_s = d; req_s = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      req_s = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (m_en[i]) begin
          r_en_cnt[i]++;
          if (r_en_cyc[i] < 0) begin
            r_en_cyc[i] = k; r_we[i] = m_we[i]; r_wdata[i] = m_wdata[i]; r_addr[i] = m_addr[i];
          end
        end
        if (m_valid[i]) begin
          r_val_cnt[i]++;
          if (r_val_cyc[i] < 0) begin
            r_val_cyc[i] = k; r_err[i] = m_err[i]; r_rdata[i] = m_rdata[i];
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_s = 1'b0; addr_s = 16'h0; size_s = 2'b00; we_s = 4'h0; wdata_s = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++; if ({bus0.cpu_valid, bus0.cpu_err, bus0.cpu_busy, bus0.sram_en, bus0.sram_we} !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl0: got %h expected 00", {bus0.cpu_valid, bus0.cpu_err, bus0.cpu_busy, bus0.sram_en, bus0.sram_we}); end
    n_checks++; if ({bus3.cpu_valid, bus3.cpu_err, bus3.cpu_busy, bus3.sram_en, bus3.sram_we} !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl3: got %h expected 00", {bus3.cpu_valid, bus3.cpu_err, bus3.cpu_busy, bus3.sram_en, bus3.sram_we}); end
    n_checks++; if ({bus0.cpu_rdata, bus0.sram_wdata, bus0.sram_addr} !== 78'h0) begin n_fail++; $display("FAIL reset_data0: got %h expected 0", {bus0.cpu_rdata, bus0.sram_wdata, bus0.sram_addr}); end
    n_checks++; if ({bus3.cpu_rdata, bus3.sram_wdata, bus3.sram_addr} !== 78'h0) begin n_fail++; $display("FAIL reset_data3: got %h expected 0", {bus3.cpu_rdata, bus3.sram_wdata, bus3.sram_addr}); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (m_busy !== 2'b00) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 00", m_busy); end
  endtask

  task automatic test_word_store_load();
    run_access(16'h0010, 2'b10, 4'b1111, 32'hDEAD_BEEF);
    n_checks++; if (r_en_cyc[0] !== 1) begin n_fail++; $display("FAIL st_word_en_cyc: got %0d expected 1", r_en_cyc[0]); end
    n_checks++; if (r_en_cnt[0] !== 1) begin n_fail++; $display("FAIL st_word_en_cnt: got %0d expected 1", r_en_cnt[0]); end
    n_checks++; if (r_we[0] !== 4'b1111) begin n_fail++; $display("FAIL st_word_we: got %b expected 1111", r_we[0]); end
    n_checks++; if (r_addr[0] !== 14'h004) begin n_fail++; $display("FAIL st_word_addr: got %h expected 004", r_addr[0]); end
    n_checks++; if (r_wdata[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st_word_wdata: got %h expected deadbeef", r_wdata[0]); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (r_val_cyc[i] !== 2) begin n_fail++; $display("FAIL st_word_valid_cyc[%0d]: got %0d expected 2", i, r_val_cyc[i]); end
      n_checks++; if (r_val_cnt[i] !== 1 || r_err[i] !== 1'b0) begin n_fail++; $display("FAIL st_word_valid_once[%0d]: got cnt %0d err %b expected 1/0", i, r_val_cnt[i], r_err[i]); end
    end
    run_access(16'h0010, 2'b10, 4'b0000, 32'h0);
    n_checks++; if (r_en_cyc[0] !== 1 || r_we[0] !== 4'b0000) begin n_fail++; $display("FAIL ld_word_en: got cyc %0d we %b expected 1/0000", r_en_cyc[0], r_we[0]); end
    n_checks++; if (r_val_cyc[0] !== 3) begin n_fail++; $display("FAIL ld_word_valid_cyc0: got %0d expected 3", r_val_cyc[0]); end
    n_checks++; if (r_val_cyc[1] !== 6) begin n_fail++; $display("FAIL ld_word_valid_cyc3: got %0d expected 6", r_val_cyc[1]); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (r_rdata[i] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_word_rdata[%0d]: got %h expected deadbeef", i, r_rdata[i]); end
    end
  endtask

  task automatic test_byte();
    run_access(16'h0013, 2'b00, 4'b0001, 32'h0000_00AB);
    n_checks++; if (r_we[0] !== 4'b1000) begin n_fail++; $display("FAIL st_byte_we: got %b expected 1000", r_we[0]); end
    n_checks++; if (r_wdata[0] !== 32'hAB00_0000) begin n_fail++; $display("FAIL st_byte_wdata: got %h expected ab000000", r_wdata[0]); end
    n_checks++; if (r_addr[0] !== 14'h004) begin n_fail++; $display("FAIL st_byte_addr: got %h expected 004", r_addr[0]); end
    run_access(16'h0013, 2'b00, 4'b0000, 32'h0);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (r_rdata[i] !== 32'h0000_00AB) begin n_fail++; $display("FAIL ld_byte_rdata[%0d]: got %h expected 000000ab", i, r_rdata[i]); end
    end
  endtask

  task automatic test_half();
    run_access(16'h0010, 2'b10, 4'b1111, 32'h8001_7FFF);
    n_checks++; if (r_rdata[0] !== 32'h0000_00AB) begin n_fail++; $display("FAIL store_keeps_rdata: got %h expected 000000ab", r_rdata[0]); end
    run_access(16'h0012, 2'b01, 4'b0000, 32'h0);
    n_checks++; if (r_val_cyc[0] !== 3) begin n_fail++; $display("FAIL ld_half_valid_cyc0: got %0d expected 3", r_val_cyc[0]); end
    n_checks++; if (r_val_cyc[1] !== 6) begin n_fail++; $display("FAIL ld_half_valid_cyc3: got %0d expected 6", r_val_cyc[1]); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (r_rdata[i] !== 32'h0000_8001) begin n_fail++; $display("FAIL ld_half_hi_rdata[%0d]: got %h expected 00008001", i, r_rdata[i]); end
    end
    run_access(16'h0010, 2'b01, 4'b0000, 32'h0);
    n_checks++; if (r_rdata[0] !== 32'h0000_7FFF) begin n_fail++; $display("FAIL ld_half_lo_rdata: got %h expected 00007fff", r_rdata[0]); end
    run_access(16'h0011, 2'b00, 4'b0000, 32'h0);
    n_checks++; if (r_rdata[0] !== 32'h0000_007F) begin n_fail++; $display("FAIL ld_byte1_rdata: got %h expected 0000007f", r_rdata[0]); end
    run_access(16'h0010, 2'b11, 4'b0000, 32'h0);
    n_checks++; if (r_rdata[1] !== 32'h8001_7FFF) begin n_fail++; $display("FAIL ld_size3_rdata: got %h expected 80017fff", r_rdata[1]); end
  endtask

  task automatic test_lane_masking();
    run_access(16'h0012, 2'b01, 4'b0011, 32'h0000_1234);
    n_checks++; if (r_we[0] !== 4'b1100 || r_wdata[0] !== 32'h1234_0000) begin n_fail++; $display("FAIL st_half_lanes: got we %b data %h expected 1100/12340000", r_we[0], r_wdata[0]); end
    run_access(16'h0012, 2'b01, 4'b0000, 32'h0);
    n_checks++; if (r_rdata[1] !== 32'h0000_1234) begin n_fail++; $display("FAIL ld_half_after_st: got %h expected 00001234", r_rdata[1]); end
    run_access(16'h0031, 2'b00, 4'b1111, 32'h0000_00CD);
    n_checks++; if (r_we[0] !== 4'b0010 || r_wdata[0] !== 32'h0000_CD00 || r_addr[0] !== 14'h00C) begin n_fail++; $display("FAIL st_byte_masked: got we %b data %h addr %h expected 0010/0000cd00/00c", r_we[0], r_wdata[0], r_addr[0]); end
  endtask

  task automatic test_misaligned();
    run_access(16'h0011, 2'b10, 4'b0000, 32'h0);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (r_val_cyc[i] !== 1 || r_err[i] !== 1'b1) begin n_fail++; $display("FAIL mis_word_valid[%0d]: got cyc %0d err %b expected 1/1", i, r_val_cyc[i], r_err[i]); end
      n_checks++; if (r_rdata[i] !== 32'h0 || r_en_cnt[i] !== 0) begin n_fail++; $display("FAIL mis_word_no_sram[%0d]: got rdata %h en %0d expected 0/0", i, r_rdata[i], r_en_cnt[i]); end
    end
    run_access(16'h0015, 2'b01, 4'b0011, 32'h0000_5555);
    n_checks++; if (r_val_cyc[0] !== 1 || r_err[0] !== 1'b1 || r_en_cnt[0] !== 0) begin n_fail++; $display("FAIL mis_half: got cyc %0d err %b en %0d expected 1/1/0", r_val_cyc[0], r_err[0], r_en_cnt[0]); end
    run_access(16'h0010, 2'b10, 4'b0000, 32'h0);
    n_checks++; if (r_err[0] !== 1'b0 || r_rdata[0] !== 32'h1234_7FFF) begin n_fail++; $display("FAIL ld_after_mis: got err %b rdata %h expected 0/12347fff", r_err[0], r_rdata[0]); end
  endtask

  task automatic test_back_to_back();
    int en_cnt [2], val_cnt [2], last_val [2], gap_err [2];
    wait_idle();
    for (int i = 0; i < 2; i++) begin en_cnt[i] = 0; val_cnt[i] = 0; last_val[i] = -1; gap_err[i] = 0; end
    addr_s = 16'h0020; size_s = 2'b10; we_s = 4'b0000; wdata_s = 32'h0; req_s = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (m_en[i]) begin
          en_cnt[i]++;
          if (last_val[i] >= 0 && (k - last_val[i]) != 2) gap_err[i]++;
        end
        if (m_valid[i]) begin val_cnt[i]++; last_val[i] = k; end
      end
    end
    req_s = 1'b0;
    n_checks++; if (en_cnt[0] !== 10 || val_cnt[0] !== 10) begin n_fail++; $display("FAIL b2b_counts0: got en %0d valid %0d expected 10/10", en_cnt[0], val_cnt[0]); end
    n_checks++; if (en_cnt[1] !== 6 || val_cnt[1] !== 5) begin n_fail++; $display("FAIL b2b_counts3: got en %0d valid %0d expected 6/5", en_cnt[1], val_cnt[1]); end
    n_checks++; if (gap_err[0] !== 0 || gap_err[1] !== 0) begin n_fail++; $display("FAIL b2b_accept_gap: got %0d/%0d early accepts expected 0/0", gap_err[0], gap_err[1]); end
    wait_idle();
  endtask

  task automatic test_reset_mid_access();
    int stray = 0;
    wait_idle();
    addr_s = 16'h0040; size_s = 2'b10; we_s = 4'b1111; wdata_s = 32'h1111_1111; req_s = 1'b1;
    @(negedge clk);
    req_s = 1'b0;
    n_checks++; if (m_en !== 2'b11) begin n_fail++; $display("FAIL rst_pre_en: got %b expected 11", m_en); end
    reset = 1'b0;
    #1;
    n_checks++; if (m_en !== 2'b00 || bus0.sram_we !== 4'b0000 || bus3.sram_we !== 4'b0000) begin n_fail++; $display("FAIL rst_access_drop: got en %b we %b/%b expected 00/0000/0000", m_en, bus0.sram_we, bus3.sram_we); end
    @(negedge clk);
    reset = 1'b1;
    wait_idle();
    addr_s = 16'h0010; size_s = 2'b10; we_s = 4'b0000; req_s = 1'b1;
    repeat (3) @(negedge clk);
    req_s = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++; if (m_busy !== 2'b00 || m_valid !== 2'b00 || m_en !== 2'b00) begin n_fail++; $display("FAIL rst_wait_abort: got busy %b valid %b en %b expected 00/00/00", m_busy, m_valid, m_en); end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid != 2'b00 || m_busy != 2'b00) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rst_no_valid: got %0d active cycles expected 0", stray); end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_word_store_load();
    test_byte();
    test_half();
    test_lane_masking();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
